mul_pipe: RTL and testbench
===========================

// Module: mul_pipe
// PURPOSE
//  Parametrised, fully pipelined integer multiplier for the RV64 M-extension execute port.
//  Accepts one op per cycle with valid/ready on both sides and supports MUL/MULH/MULHSU/MULHU/MULW.
//  Tags results with ROB and PRF pointers; flushes all in-flight ops on pipeline squash.
//  Sits between the issue queue and the writeback/complete bus.
// PARAMETERS
//  XLEN    64  operand/result width (32 or 64; W ops exist only when XLEN==64)
//  LAT     3   cycles from accept to out_valid; legal range 1..8
//  ROB_W   6   ROB pointer width
//  PRF_W   7   physical register pointer width
// PORTS
//  clk          in   1      clock
//  reset        in   1      synchronous, active-high
//  flush        in   1      squash all in-flight ops, including one presented this cycle
//  in_valid     in   1      op presented
//  in_ready     out  1      op accepted when in_valid & in_ready
//  op           in   2      mul_op_t: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU
//  is_w         in   1      32-bit word op (MULW)
//  src_a        in   XLEN   rs1
//  src_b        in   XLEN   rs2
//  rob_ptr_in   in   ROB_W  ROB tag
//  prf_ptr_in   in   PRF_W  destination physical register
//  wb_en_in     in   1      destination write required (0 when rd==x0)
//  out_valid    out  1      result valid
//  out_ready    in   1      consumer accepts result
//  y            out  XLEN   result
//  rob_ptr_out  out  ROB_W  tag of y
//  prf_ptr_out  out  PRF_W  destination of y
//  wb_en_out    out  1      write-enable for y; asserted only while out_valid
//  inflight     out  4      number of valid ops in the pipeline (0..LAT)
// BEHAVIOUR
//  - Reset: all stage valid bits cleared; out_valid=0, wb_en_out=0, y=0, ptrs=0, inflight=0.
//  - Stage data registers are reset to 0 as well (a deterministic y is required).
//  - Pipeline has LAT stages; the global advance enable is adv = !v[LAT-1] | out_ready.
//  - in_ready = adv & !flush. Accept at edge k -> out_valid high in the cycle after edge k+LAT-1
//    (no stalls), i.e. latency LAT.
//  - When adv=0 all stages hold and bubbles are not collapsed. The output stays stable until out_ready.
//  - Flush: at the next edge all v[] clear and the input is dropped. Flush has priority over
//    accept and stall, and out_valid is 0 in the following cycle.
//  - Reset has priority over flush; reset mid-operation discards everything.
//  - Arithmetic (2*XLEN product p):
//      MUL    -> p[XLEN-1:0]
//      MULH   -> signed(a) * signed(b), p[2XLEN-1:XLEN]
//      MULHSU -> signed(a) * unsigned(b), high half
//      MULHU  -> unsigned * unsigned, high half
//  - is_w: p = a[31:0]*b[31:0]; y = sext64(p[31:0]). op is ignored for W (decode guarantees MUL).
//    When XLEN==32, is_w is ignored.
//  - Product is computed in stage 0 and retimed across stages. Mode/sign-select bits travel with the data.
//  - inflight = popcount(v[]). It updates each edge: +accept, -(out_valid & out_ready), and goes to 0 on flush.
//  - Simultaneous accept and output drain while full is legal and sustains 1 op/cycle.
// STRUCTURE
//  - Package mul_pkg: mul_op_t enum (MUL_LO, MUL_HSS, MUL_HSU, MUL_HUU) and MUL_MAX_LAT=8.
//  - Sub-module mul_operand_prep: combinational; produces the sign/zero-extended 2*XLEN operands
//    from op, is_w and the sources.
//  - Pipeline valid/tag registers are shift arrays [LAT]; the data array is [LAT] of 2*XLEN bits.
//    The final high/low/W select is combinational from the last stage.
// TESTING
//  1. MULHU a=FFFF_FFFF_FFFF_FFFF, b=2 -> y=1 after exactly LAT cycles, ROB/PRF tags echoed.
//  2. MULH a=-1, b=-1 -> y=0. MULHSU a=-1, b=FFFF_FFFF_FFFF_FFFF -> y=FFFF_FFFF_FFFF_FFFF.
//     MUL a=-3, b=5 -> y=FFFF_FFFF_FFFF_FFF1.
//  3. MULW a=0000_0001_8000_0000, b=2 -> y=0 (low 32 bits = 0). MULW a=4000_0000, b=2
//     -> y=FFFF_FFFF_8000_0000.
//  4. Back-to-back stream of LAT+3 ops with out_ready=0 for 5 cycles:
//     - in_ready drops once full; inflight==LAT;
//     - order preserved after release, no loss/duplication, y stable while stalled.
//  5. Flush with 2 ops in flight plus in_valid asserted -> no out_valid for those ops and inflight==0
//     next cycle. An op issued the cycle after flush completes normally.
//  6. Reset asserted mid-stream with LAT=1 and LAT=5 builds -> outputs 0 next cycle;
//     random op/operand sweep vs reference model.

Source files
------------

// File: rtl/mul_pkg.sv
// Shared types and limits for the pipelined integer multiplier.
package mul_pkg;

    typedef enum logic [1:0] {
        MUL_LO  = 2'd0,   // low half of the product
        MUL_HSS = 2'd1,   // high half, signed x signed
        MUL_HSU = 2'd2,   // high half, signed x unsigned
        MUL_HUU = 2'd3    // high half, unsigned x unsigned
    } mul_op_t;

    localparam int unsigned MUL_MAX_LAT = 8;

    // rs1 is sign-extended for the signed-a high-half ops
    function automatic logic op_a_signed(mul_op_t op);
        return (op == MUL_HSS) || (op == MUL_HSU);
    endfunction

    // rs2 is sign-extended only for signed x signed
    function automatic logic op_b_signed(mul_op_t op);
        return (op == MUL_HSS);
    endfunction

endpackage

// File: rtl/mul_operand_prep.sv
// Builds the 2*XLEN-bit multiplier operands and the result-select bits
// from the opcode, the word flag and the raw sources.
module mul_operand_prep
    import mul_pkg::*;
#(
    parameter int unsigned XLEN = 64
) (
    input  logic [1:0]        op,
    input  logic              is_w,
    input  logic [XLEN-1:0]   src_a,
    input  logic [XLEN-1:0]   src_b,
    output logic [2*XLEN-1:0] a_ext,
    output logic [2*XLEN-1:0] b_ext,
    output logic              sel_hi,
    output logic              sel_w
);

    mul_op_t op_e;
    logic    w_mode;
    logic    a_sgn;
    logic    b_sgn;

    // Decode mode and extend operands; word ops only need the low 32 bits of the product
    always_comb begin
        op_e   = mul_op_t'(op);
        w_mode = (XLEN == 64) && is_w;
        a_sgn  = !w_mode && op_a_signed(op_e);
        b_sgn  = !w_mode && op_b_signed(op_e);
        if (w_mode) begin
            a_ext = {{(2*XLEN-32){1'b0}}, src_a[31:0]};
            b_ext = {{(2*XLEN-32){1'b0}}, src_b[31:0]};
        end else begin
            a_ext = {{XLEN{a_sgn & src_a[XLEN-1]}}, src_a};
            b_ext = {{XLEN{b_sgn & src_b[XLEN-1]}}, src_b};
        end
        sel_hi = !w_mode && (op_e != MUL_LO);
        sel_w  = w_mode;
    end

endmodule

// File: rtl/mul_pipe.sv
// Fully pipelined RV64 M-extension multiplier. The product is formed in
// stage 0 and carried through LAT stages (legal LAT 1..MUL_MAX_LAT) with
// its ROB/PRF tags; all stages advance together under a single enable.
module mul_pipe
    import mul_pkg::*;
#(
    parameter int unsigned XLEN  = 64,
    parameter int unsigned LAT   = 3,
    parameter int unsigned ROB_W = 6,
    parameter int unsigned PRF_W = 7
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       op,
    input  logic             is_w,
    input  logic [XLEN-1:0]  src_a,
    input  logic [XLEN-1:0]  src_b,
    input  logic [ROB_W-1:0] rob_ptr_in,
    input  logic [PRF_W-1:0] prf_ptr_in,
    input  logic             wb_en_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  y,
    output logic [ROB_W-1:0] rob_ptr_out,
    output logic [PRF_W-1:0] prf_ptr_out,
    output logic             wb_en_out,
    output logic [3:0]       inflight
);

    localparam int unsigned LAST = LAT - 1;

    logic [LAT-1:0]                 v_q;
    logic [LAT-1:0][2*XLEN-1:0]     prod_q;
    logic [LAT-1:0][ROB_W-1:0]      rob_q;
    logic [LAT-1:0][PRF_W-1:0]      prf_q;
    logic [LAT-1:0]                 wb_q;
    logic [LAT-1:0]                 hi_q;
    logic [LAT-1:0]                 w_q;

    logic [2*XLEN-1:0] a_ext;
    logic [2*XLEN-1:0] b_ext;
    logic [2*XLEN-1:0] prod_d;
    logic              sel_hi;
    logic              sel_w;
    logic              adv;
    logic              accept;
    logic signed [31:0] lo32;
    logic [3:0]        cnt;

    mul_operand_prep #(
        .XLEN (XLEN)
    ) u_prep (
        .op     (op),
        .is_w   (is_w),
        .src_a  (src_a),
        .src_b  (src_b),
        .a_ext  (a_ext),
        .b_ext  (b_ext),
        .sel_hi (sel_hi),
        .sel_w  (sel_w)
    );

    // Global advance, input handshake and the stage-0 product
    always_comb begin
        adv      = !v_q[LAST] || out_ready;
        in_ready = adv && !flush;
        accept   = in_valid && in_ready;
        prod_d   = a_ext * b_ext;
    end

    // Valid shift register: reset beats flush, flush beats advance/stall
    always_ff @(posedge clk) begin
        if (reset) begin
            v_q <= '0;
        end else if (flush) begin
            v_q <= '0;
        end else if (adv) begin
            v_q[0] <= accept;
            for (int unsigned i = 1; i < LAT; i++) begin
                v_q[i] <= v_q[i-1];
            end
        end
    end

    // Data/tag shift registers; a stage only loads when a valid op moves into it
    always_ff @(posedge clk) begin
        if (reset) begin
            prod_q <= '0;
            rob_q  <= '0;
            prf_q  <= '0;
            wb_q   <= '0;
            hi_q   <= '0;
            w_q    <= '0;
        end else if (adv) begin
            if (accept) begin
                prod_q[0] <= prod_d;
                rob_q[0]  <= rob_ptr_in;
                prf_q[0]  <= prf_ptr_in;
                wb_q[0]   <= wb_en_in;
                hi_q[0]   <= sel_hi;
                w_q[0]    <= sel_w;
            end
            for (int unsigned i = 1; i < LAT; i++) begin
                if (v_q[i-1]) begin
                    prod_q[i] <= prod_q[i-1];
                    rob_q[i]  <= rob_q[i-1];
                    prf_q[i]  <= prf_q[i-1];
                    wb_q[i]   <= wb_q[i-1];
                    hi_q[i]   <= hi_q[i-1];
                    w_q[i]    <= w_q[i-1];
                end
            end
        end
    end

    // Result select from the last stage: word sign-extend, high half or low half
    always_comb begin
        lo32        = prod_q[LAST][31:0];
        out_valid   = v_q[LAST];
        wb_en_out   = v_q[LAST] && wb_q[LAST];
        rob_ptr_out = rob_q[LAST];
        prf_ptr_out = prf_q[LAST];
        if (w_q[LAST]) begin
            y = XLEN'(lo32);
        end else if (hi_q[LAST]) begin
            y = prod_q[LAST][2*XLEN-1:XLEN];
        end else begin
            y = prod_q[LAST][XLEN-1:0];
        end
    end

    // Occupancy is the population count of the stage valid bits
    always_comb begin
        cnt = '0;
        for (int unsigned i = 0; i < LAT; i++) begin
            cnt = cnt + 4'(v_q[i]);
        end
        inflight = cnt;
    end

endmodule

// File: tb/tb_mul_pipe.sv
// Scoreboard bench for mul_pipe: three builds (LAT 3, 1, 5) share stimulus;
// each build has its own expected-result queue fed on accept.
module tb_mul_pipe;

    localparam int LAT = 3;

    typedef struct {
        logic [63:0] y;
        logic [5:0]  rob;
        logic [6:0]  prf;
        logic        wb;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset, flush, in_valid, out_ready, is_w, wb_en_in;
    logic [1:0]  op;
    logic [63:0] src_a, src_b;
    logic [5:0]  rob_ptr_in;
    logic [6:0]  prf_ptr_in;

    logic [2:0]  ir, ov, wbo;
    logic [63:0] yv   [3];
    logic [5:0]  robo [3];
    logic [6:0]  prfo [3];
    logic [3:0]  inf  [3];

    int   lat_of [3] = '{3, 1, 5};
    exp_t sbq [3][$];
    int   n_cmp = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    mul_pipe #(.XLEN(64), .LAT(3), .ROB_W(6), .PRF_W(7)) u_dut (
        .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(ir[0]),
        .op(op), .is_w(is_w), .src_a(src_a), .src_b(src_b), .rob_ptr_in(rob_ptr_in),
        .prf_ptr_in(prf_ptr_in), .wb_en_in(wb_en_in), .out_valid(ov[0]), .out_ready(out_ready),
        .y(yv[0]), .rob_ptr_out(robo[0]), .prf_ptr_out(prfo[0]), .wb_en_out(wbo[0]), .inflight(inf[0]));

    mul_pipe #(.XLEN(64), .LAT(1), .ROB_W(6), .PRF_W(7)) u_lat1 (
        .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(ir[1]),
        .op(op), .is_w(is_w), .src_a(src_a), .src_b(src_b), .rob_ptr_in(rob_ptr_in),
        .prf_ptr_in(prf_ptr_in), .wb_en_in(wb_en_in), .out_valid(ov[1]), .out_ready(out_ready),
        .y(yv[1]), .rob_ptr_out(robo[1]), .prf_ptr_out(prfo[1]), .wb_en_out(wbo[1]), .inflight(inf[1]));

    mul_pipe #(.XLEN(64), .LAT(5), .ROB_W(6), .PRF_W(7)) u_lat5 (
        .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(ir[2]),
        .op(op), .is_w(is_w), .src_a(src_a), .src_b(src_b), .rob_ptr_in(rob_ptr_in),
        .prf_ptr_in(prf_ptr_in), .wb_en_in(wb_en_in), .out_valid(ov[2]), .out_ready(out_ready),
        .y(yv[2]), .rob_ptr_out(robo[2]), .prf_ptr_out(prfo[2]), .wb_en_out(wbo[2]), .inflight(inf[2]));

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    // Reference: unsigned product, then signed high halves by correction terms
    function automatic logic [63:0] model(input logic [1:0] o, input logic w,
                                          input logic [63:0] a, input logic [63:0] b);
        logic [127:0] pu;
        logic [63:0]  hi, p32;
        if (w) begin
            p32 = {32'h0, a[31:0]} * {32'h0, b[31:0]};
            return {{32{p32[31]}}, p32[31:0]};
        end
        pu = {64'h0, a} * {64'h0, b};
        hi = pu[127:64];
        case (o)
            2'd0:    return pu[63:0];
            2'd1:    return hi - (a[63] ? b : 64'h0) - (b[63] ? a : 64'h0);
            2'd2:    return hi - (a[63] ? b : 64'h0);
            default: return hi;
        endcase
    endfunction

    function automatic logic [63:0] pick();
        case ($urandom_range(0, 5))
            0:       return 64'h0;
            1:       return 64'hFFFF_FFFF_FFFF_FFFF;
            2:       return 64'h8000_0000_0000_0000;
            3:       return 64'h7FFF_FFFF_FFFF_FFFF;
            4:       return {32'h0, 32'($urandom())};
            default: return {32'($urandom()), 32'($urandom())};
        endcase
    endfunction

    // Scoreboard: pop on output handshake, push on input accept, drop all on reset/flush
    always @(negedge clk) begin
        exp_t e;
        for (int d = 0; d < 3; d++) begin
            if (reset || flush) begin
                sbq[d].delete();
            end else begin
                if (ov[d] && out_ready) begin
                    if (sbq[d].size() == 0) begin
                        chk($sformatf("spurious_out_L%0d", lat_of[d]), 64'(ov[d]), 64'd0);
                    end else begin
                        e = sbq[d].pop_front();
                        chk($sformatf("y_L%0d", lat_of[d]), yv[d], e.y);
                        chk($sformatf("rob_L%0d", lat_of[d]), 64'(robo[d]), 64'(e.rob));
                        chk($sformatf("prf_L%0d", lat_of[d]), 64'(prfo[d]), 64'(e.prf));
                        chk($sformatf("wb_L%0d", lat_of[d]), 64'(wbo[d]), 64'(e.wb));
                    end
                end
                if (in_valid && ir[d]) begin
                    e.y   = model(op, is_w, src_a, src_b);
                    e.rob = rob_ptr_in;
                    e.prf = prf_ptr_in;
                    e.wb  = wb_en_in;
                    sbq[d].push_back(e);
                end
            end
        end
    end

    task automatic drive(input logic [1:0] o, input logic w, input logic [63:0] a,
                         input logic [63:0] b, input logic [5:0] r, input logic [6:0] p,
                         input logic we);
        op = o; is_w = w; src_a = a; src_b = b;
        rob_ptr_in = r; prf_ptr_in = p; wb_en_in = we; in_valid = 1'b1;
    endtask

    // Waits (bounded) for the LAT=3 build to accept the presented op; returns at #1 after that edge
    task automatic wait_accept(input bit rnd, output int waits);
        waits = 0;
        if (rnd) out_ready = ($urandom_range(0, 3) != 0);
        forever begin
            @(negedge clk);
            if (ir[0]) break;
            waits++;
            if (waits >= 50) begin
                chk("accept_timeout", 64'(ir[0]), 64'd1);
                break;
            end
            @(posedge clk); #1;
            if (rnd) out_ready = ($urandom_range(0, 3) != 0);
        end
        @(posedge clk); #1;
    endtask

    task automatic drain();
        int n;
        in_valid = 1'b0; out_ready = 1'b1; n = 0;
        while ((sbq[0].size() + sbq[1].size() + sbq[2].size()) != 0 && n < 60) begin
            @(posedge clk); #1;
            n++;
        end
        chk("drain_left", 64'(sbq[0].size() + sbq[1].size() + sbq[2].size()), 64'd0);
    endtask

    task automatic run_one(input logic [1:0] o, input logic w, input logic [63:0] a,
                           input logic [63:0] b, input logic [63:0] expy, input string tag);
        int waits;
        bit seen;
        out_ready = 1'b1;
        drive(o, w, a, b, 6'h11, 7'h22, 1'b1);
        wait_accept(1'b0, waits);
        in_valid = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (ov[0]) begin
                seen = 1'b1;
                chk(tag, yv[0], expy);
            end
        end
        if (!seen) chk({tag, "_timeout"}, 64'(seen), 64'd1);
        drain();
    endtask

    task automatic chk_zero_all(input string tag);
        for (int d = 0; d < 3; d++) begin
            chk($sformatf("%s_valid_L%0d", tag, lat_of[d]), 64'(ov[d]), 64'd0);
            chk($sformatf("%s_y_L%0d", tag, lat_of[d]), yv[d], 64'd0);
            chk($sformatf("%s_rob_L%0d", tag, lat_of[d]), 64'(robo[d]), 64'd0);
            chk($sformatf("%s_prf_L%0d", tag, lat_of[d]), 64'(prfo[d]), 64'd0);
            chk($sformatf("%s_wb_L%0d", tag, lat_of[d]), 64'(wbo[d]), 64'd0);
            chk($sformatf("%s_inflight_L%0d", tag, lat_of[d]), 64'(inf[d]), 64'd0);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int          waits;
        logic [63:0] y_hold;
        logic [1:0]  ro;
        logic        rw;

        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        op = '0; is_w = 1'b0; src_a = '0; src_b = '0;
        rob_ptr_in = '0; prf_ptr_in = '0; wb_en_in = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk_zero_all("reset");
        @(posedge clk); #1;

        // MULHU max*2: result after exactly LAT edges with tags echoed
        drive(2'd3, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 6'h2A, 7'h55, 1'b1);
        wait_accept(1'b0, waits);
        in_valid = 1'b0;
        for (int i = 0; i < LAT - 1; i++) begin
            @(negedge clk);
            chk($sformatf("lat_early_%0d", i), 64'(ov[0]), 64'd0);
        end
        @(negedge clk);
        chk("lat_valid", 64'(ov[0]), 64'd1);
        chk("mulhu_y", yv[0], 64'd1);
        chk("mulhu_rob", 64'(robo[0]), 64'h2A);
        chk("mulhu_prf", 64'(prfo[0]), 64'h55);
        chk("mulhu_wb", 64'(wbo[0]), 64'd1);
        drain();

        run_one(2'd1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, "mulh_m1");
        run_one(2'd2, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF,
                64'hFFFF_FFFF_FFFF_FFFF, "mulhsu_m1");
        run_one(2'd0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFD, 64'd5, 64'hFFFF_FFFF_FFFF_FFF1, "mul_m3x5");
        run_one(2'd0, 1'b1, 64'h0000_0001_8000_0000, 64'd2, 64'd0, "mulw_wrap");
        run_one(2'd0, 1'b1, 64'h0000_0000_4000_0000, 64'd2, 64'hFFFF_FFFF_8000_0000, "mulw_neg");

        // Stall: fill with out_ready low, hold, then release and stream
        out_ready = 1'b0;
        for (int k = 0; k < LAT; k++) begin
            drive(2'(k), 1'b0, 64'(k + 100), 64'(k + 7), 6'(k), 7'(k + 40), 1'b1);
            wait_accept(1'b0, waits);
        end
        drive(2'd3, 1'b0, 64'hDEAD_BEEF_0000_0003, 64'h1234, 6'd3, 7'd43, 1'b1);
        y_hold = '0;
        for (int s = 0; s < 2; s++) begin
            @(negedge clk);
            chk("stall_in_ready", 64'(ir[0]), 64'd0);
            chk("stall_inflight", 64'(inf[0]), 64'(LAT));
            chk("stall_valid", 64'(ov[0]), 64'd1);
            if (s == 0) y_hold = yv[0];
            else chk("stall_y_stable", yv[0], y_hold);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        wait_accept(1'b0, waits);
        for (int k = 4; k < LAT + 3; k++) begin
            drive(2'(k), 1'b0, 64'(k * 3 + 1), 64'hFFFF_0000_0000_0000 | 64'(k), 6'(k), 7'(k + 40), 1'(k));
            wait_accept(1'b0, waits);
            chk($sformatf("full_rate_%0d", k), 64'(waits), 64'd0);
            chk($sformatf("full_inflight_%0d", k), 64'(inf[0]), 64'(LAT));
        end
        drain();

        // Flush with two ops in flight and a third presented
        drive(2'd0, 1'b0, 64'd11, 64'd13, 6'd20, 7'd60, 1'b1);
        wait_accept(1'b0, waits);
        drive(2'd3, 1'b0, 64'd17, 64'd19, 6'd21, 7'd61, 1'b1);
        wait_accept(1'b0, waits);
        drive(2'd1, 1'b0, 64'd23, 64'd29, 6'd22, 7'd62, 1'b1);
        flush = 1'b1;
        @(negedge clk);
        chk("flush_in_ready", 64'(ir[0]), 64'd0);
        @(posedge clk); #1;
        flush = 1'b0;
        drive(2'd0, 1'b0, 64'd31, 64'd37, 6'd23, 7'd63, 1'b1);
        @(negedge clk);
        chk("flush_valid", 64'(ov[0]), 64'd0);
        chk("flush_inflight", 64'(inf[0]), 64'd0);
        @(posedge clk); #1;
        in_valid = 1'b0;
        drain();

        // Random sweep with back-pressure and a mid-stream reset
        for (int i = 0; i < 160; i++) begin
            rw = ($urandom_range(0, 3) == 0);
            ro = rw ? 2'd0 : 2'($urandom_range(0, 3));
            drive(ro, rw, pick(), pick(), 6'($urandom()), 7'($urandom()), 1'($urandom()));
            wait_accept(1'b1, waits);
            if (i == 80) begin
                reset = 1'b1;
                @(posedge clk); #1;
                reset = 1'b0;
                in_valid = 1'b0;
                @(negedge clk);
                chk_zero_all("midreset");
                @(posedge clk); #1;
            end
        end
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
